// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and priority helper for the key debouncer
package key_pkg;

  localparam logic KEY_ACTIVE_LEVEL = 1'b0;
  localparam int   DEF_CNT_WIDTH    = 20;
  localparam int   DEF_DEBOUNCE_CNT = 999_999;
  localparam int   KEY_CODE_W       = 4;
  localparam int   KEY_MAX          = 16;

  // Scanning downwards leaves the lowest set index as the final answer.
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [KEY_MAX-1:0] vec);
    lowest_set = '0;
    for (int i = KEY_MAX - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, stability counter, level and strobes
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic press_d_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CNT);

  logic                 sync1_q, sync2_q;
  logic                 state_q, state_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 raw;

  assign raw = (sync2_q == KEY_ACTIVE_LEVEL);

  // Any sample that agrees with the current level discards accumulated credit.
  always_comb begin
    cnt_d     = '0;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (raw != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d   = raw;
        press_d   = raw;
        release_d = ~raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= ~KEY_ACTIVE_LEVEL;
      sync2_q   <= ~KEY_ACTIVE_LEVEL;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign press_d_o = press_d;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - KEY_NUM debounced keys with press/release strobes and press encoder
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM      = 8,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [KEY_NUM-1:0]    key_in,
  output logic [KEY_NUM-1:0]    key_state,
  output logic [KEY_NUM-1:0]    key_press,
  output logic [KEY_NUM-1:0]    key_release,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code
);

  logic [KEY_NUM-1:0]    press_d;
  logic                  valid_q, valid_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_ch (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .key_i    (key_in[i]),
      .state_o  (key_state[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .press_d_o(press_d[i])
    );
  end

  // Encoder works on the channels' next-state strobes so it lands on the same edge as key_press.
  always_comb begin
    valid_d = |press_d;
    code_d  = code_q;
    if (valid_d) code_d = lowest_set(KEY_MAX'(press_d));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with a run-length reference model
module tb_key_debounce;

  localparam int KN  = 8;
  localparam int DEB = 15;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic [KN-1:0] key_in    = '1;
  logic [KN-1:0] key_state, key_press, key_release;
  logic          key_valid;
  logic [3:0]    key_code;

  key_debounce #(.KEY_NUM(KN), .CNT_WIDTH(4), .DEBOUNCE_CNT(DEB)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  always #5 sys_clk = ~sys_clk;

  int edge_n = 0;
  always @(posedge sys_clk) edge_n <= edge_n + 1;

  typedef struct {
    int            cyc;
    logic [KN-1:0] press;
    logic [KN-1:0] rel;
    logic [KN-1:0] state;
    logic [3:0]    code;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference: pins reach the counter two edges late; a level is accepted after DEB+1 consecutive differing samples.
  logic [KN-1:0] m_s1, m_s2, m_state;
  int            m_run[KN];
  logic [3:0]    m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_s1    = '1;
    m_s2    = '1;
    m_state = '0;
    m_code  = '0;
    for (int i = 0; i < KN; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [KN-1:0] pins);
    logic [KN-1:0] seen, press, rel;
    ev_t e;
    seen  = ~m_s2;
    press = '0;
    rel   = '0;
    for (int i = 0; i < KN; i++) begin
      if (seen[i] != m_state[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB + 1) begin
          m_state[i] = seen[i];
          m_run[i]   = 0;
          if (seen[i]) press[i] = 1'b1;
          else         rel[i]   = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = pins;
    for (int i = KN - 1; i >= 0; i--) if (press[i]) m_code = 4'(i);
    if ((press | rel) != '0) begin
      e.cyc   = edge_n + 1;
      e.press = press;
      e.rel   = rel;
      e.state = m_state;
      e.code  = m_code;
      sb.push_back(e);
    end
  endtask

  task automatic step(input logic [KN-1:0] pins);
    @(negedge sys_clk);
    #1;
    key_in = pins;
    model_edge(pins);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {key_state, key_press, key_release, key_valid, key_code}, '0);
  endtask

  task automatic do_reset(input int cycles, output int rel_edge);
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset_async_zero");
    repeat (cycles) begin
      @(negedge sys_clk);
      check_all_zero("reset_hold_zero");
    end
    @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    rel_edge  = edge_n + 1;
    model_edge(key_in);
  endtask

  // Holds pins for 60 cycles, recording the first strobe matching the masks.
  task automatic drive_until(input logic [KN-1:0] pins, input logic [KN-1:0] pmask,
                             input logic [KN-1:0] rmask, output int first_edge,
                             output int hit_edge, output int hits,
                             output logic [KN-1:0] s_press, output logic [KN-1:0] s_rel,
                             output logic s_valid, output logic [3:0] s_code);
    hit_edge = -1000;
    hits     = 0;
    s_press  = '0;
    s_rel    = '0;
    s_valid  = 1'b0;
    s_code   = '0;
    first_edge = 0;
    for (int k = 0; k < 60; k++) begin
      step(pins);
      if (k == 0) first_edge = edge_n + 1;
      if ((key_press & pmask) != '0 || (key_release & rmask) != '0) begin
        hits++;
        if (hits == 1) begin
          hit_edge = edge_n;
          s_press  = key_press;
          s_rel    = key_release;
          s_valid  = key_valid;
          s_code   = key_code;
        end
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && (key_valid || key_press != '0 || key_release != '0)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {key_valid, key_press, key_release}, '0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("ev_cycle", edge_n, e.cyc);
          check("ev_press", key_press, e.press);
          check("ev_release", key_release, e.rel);
          check("ev_valid", key_valid, |e.press);
          check("ev_code", key_code, e.code);
          check("ev_state", key_state, e.state);
        end
      end
    end
  end

  initial begin : stim
    int            fe, he, hits, rel_edge;
    logic [KN-1:0] sp, sr, cur;
    logic          sv;
    logic [3:0]    sc;
    int            hold[KN];

    model_reset();
    key_in = '1;
    do_reset(4, rel_edge);
    repeat (100) step('1);
    check_all_zero("idle_100_zero");

    drive_until(8'hFB, 8'h04, 8'h00, fe, he, hits, sp, sr, sv, sc);
    check("press2_latency", he - fe, 17);
    check("press2_valid", sv, 1);
    check("press2_code", sc, 2);
    check("press2_hits", hits, 1);
    check("press2_state_held", key_state, 8'h04);

    drive_until(8'hFF, 8'h00, 8'h04, fe, he, hits, sp, sr, sv, sc);
    check("rel2_latency", he - fe, 17);
    check("rel2_valid", sv, 0);
    check("rel2_code_held", sc, 2);
    check("rel2_hits", hits, 1);
    check("rel2_state", key_state, 8'h00);

    repeat (10) step(8'hFB);
    repeat (3) step(8'hFF);
    drive_until(8'hFB, 8'h04, 8'h00, fe, he, hits, sp, sr, sv, sc);
    check("bounce_latency", he - fe, 17);
    check("bounce_hits", hits, 1);
    drive_until(8'hFF, 8'h00, 8'h04, fe, he, hits, sp, sr, sv, sc);

    drive_until(8'hD7, 8'h28, 8'h00, fe, he, hits, sp, sr, sv, sc);
    check("dual_latency", he - fe, 17);
    check("dual_press", sp, 8'h28);
    check("dual_code", sc, 3);
    check("dual_valid", sv, 1);
    check("dual_hits", hits, 1);
    drive_until(8'hFF, 8'h00, 8'h28, fe, he, hits, sp, sr, sv, sc);
    check("dual_release", sr, 8'h28);
    check("dual_release_code_held", sc, 3);

    repeat (9) step(8'hFE);
    do_reset(3, rel_edge);
    drive_until(8'hFE, 8'h01, 8'h00, fe, he, hits, sp, sr, sv, sc);
    check("rst_mid_latency", he - rel_edge, 17);
    check("rst_mid_code", sc, 0);
    drive_until(8'hFF, 8'h00, 8'h01, fe, he, hits, sp, sr, sv, sc);

    cur = '1;
    for (int i = 0; i < KN; i++) hold[i] = $urandom_range(1, 30);
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < KN; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = ~cur[i];
          hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : $urandom_range(16, 60);
        end else begin
          hold[i]--;
        end
      end
      if (c == 1200) begin
        key_in = cur;
        do_reset(4, rel_edge);
      end else begin
        step(cur);
      end
    end
    repeat (40) step(cur);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
